// File: rtl/adc_pkg.sv
// Shared constants for the ADC capture and readout paths: sample width,
// over-threshold level, seven-segment lookup and the readout FSM states.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_THRESH = 3643;

  // Active-low gfedcba segment patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding {data, over, last} entries for the readout
// stream. Push and pop in the same cycle leave the count unchanged.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is deliberately not reset; pointers and count define which
    // entries are meaningful, and the reader masks the head while empty.
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_buffer_reader.sv
// Read-side engine for the ADC sample RAM: streams LENGTH words starting at
// BASE_ADDR out on a valid/ready port, absorbing the RAM read latency and
// downstream backpressure, and shows the last transferred sample on the
// LEDs and the seven-segment digit.
module adc_buffer_reader
  import adc_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = ADC_DATA_W,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4,
  parameter int THRESH = ADC_THRESH
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_over,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [7:0]        leddata,
  output logic [6:0]        seven_seg
);

  localparam int                 CNT_W    = $clog2(FIFO_D + 1);
  localparam int                 ENTRY_W  = DATA_W + 2;
  localparam logic [CNT_W:0]     FIFO_D_V = (CNT_W + 1)'(FIFO_D);
  localparam logic [DATA_W-1:0]  THRESH_V = DATA_W'(THRESH);

  rd_state_t          state;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    issued_remaining;
  logic [CNT_W-1:0]   inflight;
  logic [RD_LAT-1:0]  tag_valid;
  logic [RD_LAT-1:0]  tag_last;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_wr;
  logic [ENTRY_W-1:0] fifo_rd;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [DATA_W-1:0]  head_data;
  logic               head_over;
  logic               head_last;
  logic [CNT_W:0]     outstanding;

  // Issue a read only while the FIFO is guaranteed room for every word that
  // is already queued or still travelling through the RAM pipeline.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ram_rden    = 1'b0;
    outstanding = {1'b0, fifo_count} + {1'b0, inflight};
    if (state == ST_ISSUE && issued_remaining != '0 &&
        outstanding < FIFO_D_V && !fifo_full) begin
      ram_rden = 1'b1;
    end
  end

  assign ram_address = addr_q;

  // Readout FSM: latch the request, issue reads, wait for the final transfer.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state            <= ST_IDLE;
      addr_q           <= '0;
      issued_remaining <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_q           <= base_addr;
            issued_remaining <= length;
            if (length != '0) begin
              state <= ST_ISSUE;
              busy  <= 1'b1;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (ram_rden) begin
            addr_q           <= addr_q + ADDR_W'(1);
            issued_remaining <= issued_remaining - (ADDR_W + 1)'(1);
            if (issued_remaining == (ADDR_W + 1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last word leaving the FIFO implies nothing is left in flight.
          if (pop && head_last) begin
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag pipeline mirroring the RAM latency; the oldest tag marks ram_q valid.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else begin
      tag_valid[0] <= ram_rden;
      tag_last[0]  <= ram_rden && (issued_remaining == (ADDR_W + 1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // Count of requests issued whose data has not yet reached the FIFO.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({ram_rden, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push    = tag_valid[RD_LAT-1];
  assign fifo_wr = {ram_q, (ram_q > THRESH_V), tag_last[RD_LAT-1]};

  sample_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Head fields are masked while empty so stale storage never reaches the port.
  assign head_data = fifo_empty ? '0 : fifo_rd[ENTRY_W-1:2];
  assign head_over = !fifo_empty && fifo_rd[1];
  assign head_last = !fifo_empty && fifo_rd[0];

  assign m_valid = !fifo_empty;
  assign m_data  = head_data;
  assign m_over  = head_over;
  assign m_last  = head_last;
  assign pop     = m_valid && m_ready;

  // Display registers follow the most recently transferred sample.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      leddata   <= '0;
      seven_seg <= hex_to_seg(4'h0);
    end else if (pop) begin
      leddata   <= head_data[7:0];
      seven_seg <= hex_to_seg(head_data[11:8]);
    end
  end

endmodule

// File: tb/tb_adc_buffer_reader.sv
// Self-checking bench for adc_buffer_reader: a latency-2 RAM model feeds the
// DUT, and each readout is compared against the expected word sequence
// mem[(base+i) mod 8], with threshold, last-flag, timing and display checks.
module tb_adc_buffer_reader;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 12;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 4;
  localparam int THRESH = 3643;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_over;
  logic              m_last;
  logic              busy;
  logic              done;
  logic [7:0]        leddata;
  logic [6:0]        seven_seg;

  always #5 clk_in = ~clk_in;

  adc_buffer_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .FIFO_D (FIFO_D),
    .THRESH (THRESH)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .ram_address (ram_address),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_over      (m_over),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done),
    .leddata     (leddata),
    .seven_seg   (seven_seg)
  );

  // RAM model: data appears RD_LAT cycles after the request; junk otherwise.
  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] q_pipe [RD_LAT];

  always @(posedge clk_in) begin
    q_pipe[0] <= ram_rden ? mem[ram_address] : 12'hBAD;
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_q = q_pipe[RD_LAT-1];

  logic [6:0] seg_tab [16];
  logic [7:0] exp_led;
  logic [6:0] exp_seg;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s", tag);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_rden",  ram_rden, 0);
    check("rst_addr",  ram_address, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data, 0);
    check("rst_over",  m_over, 0);
    check("rst_last",  m_last, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_led",   leddata, 0);
    check("rst_seg",   seven_seg, 7'b1000000);
  endtask

  // mode 0: m_ready always high; mode 1: random ready with a 20-cycle stall.
  // poke: pulse start with other arguments while busy; it must be ignored.
  task automatic run_readout(input int base, input int len, input int mode, input bit poke);
    logic [DATA_W-1:0] expq [$];
    logic [DATA_W-1:0] v;
    int  issued     = 0;
    int  popped     = 0;
    int  cycle      = 1;
    int  last_cycle = -1;
    bit  finished   = 0;
    for (int i = 0; i < len; i++) expq.push_back(mem[(base + i) % DEPTH]);
    start     = 1'b1;
    base_addr = base[ADDR_W-1:0];
    length    = len[ADDR_W:0];
    m_ready   = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    length    = (ADDR_W + 1)'($urandom);
    while (!finished) begin
      if (mode == 0) m_ready = 1'b1;
      else           m_ready = (cycle >= 5 && cycle < 25) ? 1'b0 : 1'($urandom_range(0, 1));
      if (poke && cycle == 3) begin
        start     = 1'b1;
        base_addr = 3'd5;
        length    = 4'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      check("led", leddata, exp_led);
      check("seg", seven_seg, exp_seg);
      if (ram_rden) begin
        check("rd_addr", ram_address, (base + issued) % DEPTH);
        check("rd_credit", (issued - popped) < FIFO_D, 1);
        check("rd_count", issued < len, 1);
        issued++;
      end
      if (mode == 0 && len > 0 && cycle == RD_LAT + 2) check("first_valid", m_valid, 1);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          fail_now("extra_word");
        end else begin
          v = expq.pop_front();
          check("data", m_data, v);
          check("over", m_over, v > THRESH);
          check("last", m_last, expq.size() == 0);
          if (mode == 0) check("stream_cycle", cycle, RD_LAT + 2 + popped);
          popped++;
          exp_led = v[7:0];
          exp_seg = seg_tab[v[11:8]];
          if (expq.size() == 0) last_cycle = cycle;
        end
      end
      if (done) begin
        check("done_cycle", cycle, (len == 0) ? 1 : last_cycle + 1);
        check("busy_at_done", busy, 0);
        finished = 1;
      end else begin
        check("busy", busy, len != 0);
      end
      if (!finished && cycle > 200) begin
        fail_now("timeout waiting for done");
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk_in);
        #1;
        cycle++;
      end
    end
    start = 1'b0;
    @(posedge clk_in);
    #1;
    check("done_once", done, 0);
    check("busy_after", busy, 0);
    check("issued_total", issued, len);
    check("words_left", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_reset_values();
    tick();
    rst     = 1'b0;
    exp_led = 8'h00;
    exp_seg = 7'h40;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    exp_led   = 8'h00;
    exp_seg   = 7'h40;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    #1;
    do_reset();

    // Full sequential readout with the consumer always ready.
    run_readout(0, 8, 0, 0);

    // Address wrap-around 6,7,0,1.
    run_readout(6, 4, 0, 0);

    // Random data and random backpressure including a long stall.
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    run_readout(0, 8, 1, 0);

    // Threshold boundary and display decode of the final word.
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom_range(0, 3000));
    mem[0] = 12'd3643;
    mem[1] = 12'd3644;
    mem[7] = 12'hA5C;
    run_readout(0, 8, 0, 0);
    check("led_a5c", leddata, 8'h5C);
    check("seg_a5c", seven_seg, 7'b0001000);

    // Zero-length readout, then a start pulse while busy.
    run_readout(3, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    run_readout(2, 6, 0, 1);

    // Reset in the middle of a readout with two reads in flight.
    start     = 1'b1;
    base_addr = 3'd0;
    length    = 4'd8;
    m_ready   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values();
    rst     = 1'b0;
    m_ready = 1'b1;
    exp_led = 8'h00;
    exp_seg = 7'h40;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_valid", m_valid, 0);
      check("post_rst_rden", ram_rden, 0);
      check("post_rst_busy", busy, 0);
    end
    run_readout(5, 7, 0, 0);

    // Random mix of readouts.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      run_readout(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
